// File: rtl/spi_cmd_master.sv
// SPI mode-0 command initiator: byte 0 = {4'b0, cmd}, optional byte 1 = write data or dummy/read.
// Define SPI_LOOPBACK_EN to capture from the internal MOSI register instead of the miso pin.
module spi_cmd_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [3:0]  RD_CODE    = 4'h1,
  parameter logic [3:0]  WR_CODE    = 4'h2,
  parameter logic [7:0]  DUMMY_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cmd,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CS_SETUP   = 3'd1;
  localparam logic [2:0] S_SHIFT_CMD  = 3'd2;
  localparam logic [2:0] S_GAP        = 3'd3;
  localparam logic [2:0] S_SHIFT_DATA = 3'd4;
  localparam logic [2:0] S_CS_HOLD    = 3'd5;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  half_q, half_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;

  logic        rx_bit;
  logic        div_end;
  logic        is_rd;
  logic        two_byte;

`ifdef SPI_LOOPBACK_EN
  logic miso_unused;
  assign miso_unused = miso;
  assign rx_bit      = tx_q[7];
`else
  assign rx_bit      = miso;
`endif

  assign div_end  = (cnt_q == DIV_LAST);
  assign is_rd    = (cmd_q == RD_CODE);
  assign two_byte = (cmd_q == RD_CODE) || (cmd_q == WR_CODE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    cmd_d      = cmd_q;
    wdat_d     = wdat_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;

    case (state_q)
      S_IDLE: begin
        // done_q gate makes a start coincident with the done pulse ignored
        if (start && !done_q) begin
          cmd_d   = cmd;
          wdat_d  = wr_data;
          tx_d    = {4'b0000, cmd};
          rx_d    = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (div_end) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT_CMD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_SHIFT_CMD, S_SHIFT_DATA: begin
        if (!div_end) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (half_q == 4'd15) begin
            sclk_d = 1'b0;
            half_d = '0;
            if ((state_q == S_SHIFT_CMD) && two_byte) begin
              tx_d    = is_rd ? DUMMY_BYTE : wdat_q;
              state_d = S_GAP;
            end else begin
              tx_d    = '0;
              state_d = S_CS_HOLD;
            end
          end else begin
            half_d = half_q + 4'd1;
            // even half -> odd half is the rising edge; odd -> even is the falling edge
            if (!half_q[0]) begin
              sclk_d = 1'b1;
              if (state_q == S_SHIFT_DATA) begin
                rx_d = {rx_q[6:0], rx_bit};
              end
            end else begin
              sclk_d = 1'b0;
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = S_SHIFT_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_CS_HOLD: begin
        if (div_end) begin
          cnt_d   = '0;
          tx_d    = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (is_rd) begin
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        tx_d    = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      cmd_q      <= '0;
      wdat_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      cmd_q      <= cmd_d;
      wdat_q     <= wdat_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;
  // tx_q is cleared whenever cs_n is high, so mosi idles low
  assign mosi     = tx_q[7];

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: stimulus queues expectations, a done-triggered monitor checks them.
module tb_spi_cmd_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cmd = 4'h0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, rd_valid, cs_n, sclk, mosi;
  logic [7:0] rd_data;
  logic       miso = 1'b0;

  spi_cmd_master #(
    .CLK_DIV(4), .GAP_CYCLES(4), .RD_CODE(4'h1), .WR_CODE(4'h2), .DUMMY_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wr_data(wr_data),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef SPI_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  function automatic logic [7:0] rd_exp(input logic [7:0] p);
    return LB ? 8'hA5 : p;
  endfunction

  // slave model: records MOSI on sclk rise, drives pat on MISO during byte 1
  logic [7:0]  pat = 8'h00;
  logic [15:0] mosi_sh = '0;
  int          rises = 0;

  always @(negedge cs_n or posedge sclk) begin
    if (!sclk) begin
      rises   = 0;
      mosi_sh = '0;
    end else if (!cs_n) begin
      mosi_sh = {mosi_sh[14:0], mosi};
      rises++;
    end
  end

`ifndef SPI_LOOPBACK_EN
  always @(negedge sclk or posedge cs_n) begin
    if (!cs_n && rises >= 8 && rises <= 15) miso = pat[15 - rises];
    else miso = 1'b0;
  end
`endif

  typedef struct {
    int          acc;
    int          lat;
    logic        rdv;
    logic [7:0]  rdd;
    logic [15:0] mosi_bits;
    int          nrise;
  } exp_t;

  exp_t expq[$];

  always @(negedge clk) begin
    if (rst_n && rd_valid && !done) chk("rd_valid_without_done", {31'd0, rd_valid}, 32'd0);
    if (rst_n && done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("latency",  32'(cyc - e.acc), 32'(e.lat));
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.rdv});
        chk("rd_data",  {24'd0, rd_data}, {24'd0, e.rdd});
        chk("mosi_bits", {16'd0, mosi_sh}, {16'd0, e.mosi_bits});
        chk("sclk_rises", 32'(rises), 32'(e.nrise));
        chk("done_cs_n", {31'd0, cs_n}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push_exp(input int acc, input int lat, input logic rdv, input logic [7:0] rdd,
                          input logic [15:0] mb, input int nr);
    exp_t e;
    e.acc = acc; e.lat = lat; e.rdv = rdv; e.rdd = rdd; e.mosi_bits = mb; e.nrise = nr;
    expq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] c, input logic [7:0] wd);
    @(negedge clk);
    cmd = c; wr_data = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_cs_n", {31'd0, cs_n}, 32'd0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        @(negedge clk);
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #23;
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // WR 3C
    push_exp(cyc + 2, 140, 1'b0, 8'h00, 16'h023C, 16);
    issue(4'h2, 8'h3C);
    wait_done("wr");

    // RD with slave returning C9
    pat = 8'hC9;
    push_exp(cyc + 2, 140, 1'b1, rd_exp(8'hC9), 16'h01A5, 16);
    issue(4'h1, 8'h00);
    wait_done("rd");

    // invalid command: single byte, rd_data kept
    push_exp(cyc + 2, 72, 1'b0, rd_exp(8'hC9), 16'h0007, 8);
    issue(4'h7, 8'hEE);
    wait_done("inv");

    // start held high throughout a WR and through its done cycle
    push_exp(cyc + 2, 140, 1'b0, rd_exp(8'hC9), 16'h025A, 16);
    @(negedge clk);
    cmd = 4'h2; wr_data = 8'h5A; start = 1'b1;
    @(negedge clk);
    cmd = 4'h7; wr_data = 8'hFF;
    begin : busy_blk
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        cmd = (cmd == 4'h7) ? 4'h1 : 4'h7;
        if (done === 1'b1) disable busy_blk;
      end
      chk("busy_timeout", 32'd0, 32'd1);
    end
    cmd = 4'h1; pat = 8'h96;
    push_exp(cyc + 2, 140, 1'b1, rd_exp(8'h96), 16'h01A5, 16);
    @(negedge clk);
    chk("start_with_done_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_after_done_accepted", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("rd2");

    // reset during SHIFT_DATA
    issue(4'h2, 8'hC3);
    repeat (95) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_mosi", {31'd0, mosi}, 32'd0);
    chk("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int dc;
      dc = done_cnt;
      repeat (200) @(negedge clk);
      chk("no_done_after_reset", 32'(done_cnt), 32'(dc));
    end
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI mode-0 initiator that issues single command transactions to the SPI slave command decoder.
- Byte 0 carries the 4-bit command. Byte 1 carries write data for WR, or a dummy byte for RD, during which read data is captured from MISO.
- Sits between the local host/control logic and the external SPI pins, on the same clock domain as the host.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles (>=1).
- GAP_CYCLES, 4: SCLK-low idle gap between byte 0 and byte 1, in clk cycles (>=1). Gives the slave time to latch the command.
- RD_CODE, 4'h1: command code for read.
- WR_CODE, 4'h2: command code for write.
- DUMMY_BYTE, 8'hA5: byte shifted out on MOSI during a read data phase.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a transaction; accepted only in IDLE.
- cmd, input, 4: command code; latched on accept.
- wr_data, input, 8: write payload; latched on accept.
- busy, output, 1: high from the accept edge until done.
- done, output, 1: one-cycle pulse at transaction end.
- rd_data, output, 8: last captured read byte.
- rd_valid, output, 1: one-cycle pulse with done, read transactions only.
- cs_n, output, 1: SPI chip select, active low.
- sclk, output, 1: SPI clock; idles low.
- mosi, output, 1: SPI data out, MSB first.
- miso, input, 1: SPI data in, sampled on SCLK rising edges.

Behaviour:
- Reset (async, rst_n low) forces all outputs immediately:
  - cs_n=1, sclk=0, mosi=0, busy=0, done=0, rd_valid=0, rd_data=8'h00.
  - State returns to IDLE.
  - Reset mid-transaction aborts it: no done, cs_n rises at once.
- States: IDLE, CS_SETUP, SHIFT_CMD, GAP, SHIFT_DATA, CS_HOLD.
- IDLE:
  - When start=1 at a clk edge, latch cmd and wr_data, set busy=1, drive cs_n=0, and enter CS_SETUP.
  - start in any other state is ignored.
- CS_SETUP: hold sclk=0 for CLK_DIV cycles; MOSI presents bit 7 of byte 0 ({4'b0000,cmd}). Then go to SHIFT_CMD.
- SHIFT_CMD / SHIFT_DATA: 8 bits, each lasting 2*CLK_DIV cycles.
  - sclk is high for the second CLK_DIV cycles of each bit.
  - MISO is sampled on the sclk rising edge.
  - MOSI updates on the falling edge to the next bit.
  - Each byte is 16*CLK_DIV cycles, and the byte ends with sclk low.
- After SHIFT_CMD:
  - If cmd is RD_CODE or WR_CODE, go to GAP (sclk=0, cs_n=0 for GAP_CYCLES), then SHIFT_DATA.
  - Otherwise, go directly to CS_HOLD as a single-byte transaction.
- SHIFT_DATA MOSI byte:
  - WR: the latched wr_data.
  - RD: DUMMY_BYTE.
  - RD also shifts the sampled MISO bits MSB-first into the capture register.
- CS_HOLD:
  - Hold cs_n=0, sclk=0 for CLK_DIV cycles.
  - Then drive cs_n=1, pulse done, clear busy, and return to IDLE.
  - For RD, rd_data updates and rd_valid pulses in the same cycle as done.
  - For WR or an invalid cmd, rd_data is unchanged and rd_valid stays 0.
- Latency from the accept edge to the done pulse, in cycles:
  - Two-byte: CLK_DIV + 16*CLK_DIV + GAP_CYCLES + 16*CLK_DIV + CLK_DIV. With defaults this is 140.
  - Single-byte: 18*CLK_DIV, which is 72 with defaults.
- A start asserted in the same cycle as done is ignored. A new transaction can begin on the next cycle.
- mosi returns to 0 whenever cs_n=1.

Optional Feature:
- SPI_LOOPBACK_EN defined: internal loopback. The capture path samples the internal MOSI register in place of the miso pin, and the miso port is ignored.
  - An RD transaction returns rd_data=DUMMY_BYTE.
- SPI_LOOPBACK_EN undefined: miso pin sampled normally; no loopback logic present.

Test Plan:
- Reset: hold rst_n=0 mid-SHIFT_DATA -> cs_n=1, sclk=0, busy=0 immediately; no done after release.
- WR: start with cmd=WR_CODE, wr_data=8'h3C -> MOSI shows 8'h02 then 8'h3C; 16 rising sclk edges; done exactly 140 cycles after accept; rd_valid=0.
- RD: start with cmd=RD_CODE, slave model drives 8'hC9 on MISO during byte 1 -> MOSI byte 1 = 8'hA5; rd_data=8'hC9; rd_valid and done pulse together at cycle 140.
- Invalid cmd: cmd=4'h7 -> only 8 sclk rising edges; done at cycle 72; rd_data unchanged.
- Busy: start pulsed repeatedly during a transaction and in the same cycle as done -> ignored; next start accepted one cycle after done.
- SPI_LOOPBACK_EN defined: RD with miso tied to 0 -> rd_data=8'hA5.
